// File: rtl/shift_normalizer.sv
// shift_normalizer: sequential left-normalizer with valid/ready on both sides.
// Shifts the accepted word left by one bit per cycle until it is normalized,
// then presents the normalized word, the shift count and a zero flag.
//
// Ports:
//   clk, nrst            clock, asynchronous active-low reset
//   in_valid / in_ready  input handshake (in_ready high only in IDLE)
//   i                    word to normalize
//   sgn                  signed normalization request (SHIFT_NORM_SIGNED_EN only)
//   out_valid / out_ready output handshake (out_valid high only in DONE)
//   o, n, zero           normalized word, left-shift count, input-was-zero
//
// Optional feature macro: SHIFT_NORM_SIGNED_EN (adds sgn and signed stop rule).
module shift_normalizer #(
   parameter int unsigned WIDTH = 8,
   localparam int unsigned CW = $clog2(WIDTH) + 1
) (
   input  logic             clk,
   input  logic             nrst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] i,
`ifdef SHIFT_NORM_SIGNED_EN
   input  logic             sgn,
`endif
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] o,
   output logic [CW-1:0]    n,
   output logic             zero
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      DONE  = 2'd2
   } state_t;

   state_t           state;
   logic [WIDTH-1:0] data;
   logic [CW-1:0]    cnt;
   logic             sgn_mode;
   logic             all_zero;
   logic             all_one;
   logic             zero_case;
   logic             stop;

`ifdef SHIFT_NORM_SIGNED_EN
   logic sgn_q;
   assign sgn_mode = sgn_q;
`else
   assign sgn_mode = 1'b0;
`endif

   // Termination tests on the registered working word.
   assign all_zero  = (data == '0);
   assign all_one   = (data == '1);
   assign zero_case = all_zero | (sgn_mode & all_one);
   assign stop      = sgn_mode ? (data[WIDTH-1] ^ data[WIDTH-2]) : data[WIDTH-1];

   // Control FSM with registered handshake and result outputs.
   always_ff @(posedge clk or negedge nrst) begin
      if (!nrst) begin
         state     <= IDLE;
         data      <= '0;
         cnt       <= '0;
         in_ready  <= 1'b1;
         out_valid <= 1'b0;
         o         <= '0;
         n         <= '0;
         zero      <= 1'b0;
`ifdef SHIFT_NORM_SIGNED_EN
         sgn_q     <= 1'b0;
`endif
      end else begin
         case (state)
            IDLE: begin
               if (in_valid) begin
                  data     <= i;
                  cnt      <= '0;
                  in_ready <= 1'b0;
                  state    <= SHIFT;
`ifdef SHIFT_NORM_SIGNED_EN
                  sgn_q    <= sgn;
`endif
               end
            end
            SHIFT: begin
               if (zero_case) begin
                  // Unsigned zero has no MSB to find; signed 0/-1 is fully redundant.
                  cnt       <= sgn_mode ? CW'(WIDTH - 1) : CW'(WIDTH);
                  n         <= sgn_mode ? CW'(WIDTH - 1) : CW'(WIDTH);
                  o         <= data << (WIDTH - 1);
                  zero      <= all_zero;
                  out_valid <= 1'b1;
                  state     <= DONE;
               end else if (stop) begin
                  o         <= data;
                  n         <= cnt;
                  zero      <= 1'b0;
                  out_valid <= 1'b1;
                  state     <= DONE;
               end else begin
                  data <= data << 1;
                  cnt  <= cnt + CW'(1);
               end
            end
            DONE: begin
               if (out_ready) begin
                  out_valid <= 1'b0;
                  in_ready  <= 1'b1;
                  state     <= IDLE;
               end
            end
            default: begin
               out_valid <= 1'b0;
               in_ready  <= 1'b1;
               state     <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_shift_normalizer.sv
// Testbench for shift_normalizer: directed and randomized operations checked
// against a leading-zero / redundant-sign-bit reference model.
module tb_shift_normalizer;

   localparam int unsigned W  = 8;
   localparam int unsigned CW = $clog2(W) + 1;

   logic          clk = 1'b0;
   logic          nrst;
   logic          in_valid;
   logic          in_ready;
   logic [W-1:0]  i;
`ifdef SHIFT_NORM_SIGNED_EN
   logic          sgn;
`endif
   logic          out_valid;
   logic          out_ready;
   logic [W-1:0]  o;
   logic [CW-1:0] n;
   logic          zero;

   int tests = 0;
   int fails = 0;

   shift_normalizer #(.WIDTH(W)) dut (
      .clk(clk), .nrst(nrst),
      .in_valid(in_valid), .in_ready(in_ready), .i(i),
`ifdef SHIFT_NORM_SIGNED_EN
      .sgn(sgn),
`endif
      .out_valid(out_valid), .out_ready(out_ready),
      .o(o), .n(n), .zero(zero)
   );

   always #5 clk = ~clk;

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached, finished=0 required=1");
      $fatal(1, "watchdog");
   end

   // Reference: count leading zeros (unsigned) or redundant sign bits (signed).
   task automatic ref_norm(input logic [W-1:0] x, input logic s,
                           output logic [W-1:0] eo, output logic [CW-1:0] en,
                           output logic ez, output int el);
      int c;
      c = 0;
      if (s && (x == '0 || x == '1)) begin
         en = CW'(W - 1);
         eo = x << (W - 1);
         ez = (x == '0);
         el = 2;
      end else if (s) begin
         for (int b = W - 2; b >= 0; b--) begin
            if (x[b] == x[W-1]) c++;
            else break;
         end
         en = CW'(c);
         eo = x << c;
         ez = 1'b0;
         el = c + 2;
      end else begin
         for (int b = W - 1; b >= 0; b--) begin
            if (x[b] == 1'b0) c++;
            else break;
         end
         en = CW'(c);
         eo = (c == W) ? '0 : (x << c);
         ez = (c == W);
         el = (c == W) ? 2 : c + 2;
      end
   endtask

   // Run one operation: accept x, wait for out_valid, hold for stall cycles,
   // then release. poke pulses in_valid with all-ones while the result waits.
   task automatic do_op(input logic [W-1:0] x, input logic s, input int stall,
                        input bit poke,
                        output logic [W-1:0] ro, output logic [CW-1:0] rn,
                        output logic rz, output int lat);
      @(negedge clk);
      in_valid  = 1'b1;
      i         = x;
      out_ready = 1'b0;
`ifdef SHIFT_NORM_SIGNED_EN
      sgn = s;
`else
      if (s) $display("[TB] note: sgn request ignored in unsigned build");
`endif
      @(posedge clk);
      lat = 1;
      #1;
      in_valid = 1'b0;
      i = W'($urandom);
      while (lat <= int'(W) + 4) begin
         @(negedge clk);
         if (out_valid) break;
         @(posedge clk);
         lat++;
      end
      ro = o; rn = n; rz = zero;
      if (!out_valid) begin
         tests++; fails++;
         $display("FAIL op_timeout: input %h out_valid=%b required=1", x, out_valid);
         return;
      end
      for (int k = 0; k < stall; k++) begin
         @(negedge clk);
         tests++;
         if (out_valid !== 1'b1 || o !== ro || n !== rn || zero !== rz || in_ready !== 1'b0) begin
            fails++;
            $display("FAIL hold: cycle %0d ov=%b o=%h n=%0d z=%b ir=%b required ov=1 o=%h n=%0d z=%b ir=0",
                     k, out_valid, o, n, zero, in_ready, ro, rn, rz);
         end
         in_valid = poke && (k == 1);
         i = '1;
      end
      in_valid  = 1'b0;
      out_ready = 1'b1;
      @(negedge clk);
      tests++;
      if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
         fails++;
         $display("FAIL release: ov=%b ir=%b required ov=0 ir=1", out_valid, in_ready);
      end
      out_ready = 1'b0;
   endtask

   task automatic test_reset();
      nrst = 1'b0; in_valid = 1'b0; i = '0; out_ready = 1'b0;
`ifdef SHIFT_NORM_SIGNED_EN
      sgn = 1'b0;
`endif
      repeat (3) @(posedge clk);
      @(negedge clk);
      nrst = 1'b1;
      @(negedge clk);
      tests++;
      if (in_ready !== 1'b1 || out_valid !== 1'b0 || o !== '0 || n !== '0 || zero !== 1'b0) begin
         fails++;
         $display("FAIL reset_state: ir=%b ov=%b o=%h n=%0d z=%b required ir=1 ov=0 o=00 n=0 z=0",
                  in_ready, out_valid, o, n, zero);
      end
   endtask

   task automatic test_directed();
      logic [W-1:0] vin [4] = '{8'h80, 8'h01, 8'h13, 8'h00};
      logic [W-1:0] xo [4]  = '{8'h80, 8'h80, 8'h98, 8'h00};
      int           xn [4]  = '{0, 7, 3, 8};
      int           xl [4]  = '{2, 9, 5, 2};
      logic [W-1:0] ro; logic [CW-1:0] rn; logic rz; int lat;
      for (int t = 0; t < 4; t++) begin
         do_op(vin[t], 1'b0, 1, 1'b0, ro, rn, rz, lat);
         tests++;
         if (ro !== xo[t] || rn !== CW'(xn[t]) || rz !== (vin[t] == '0) || lat != xl[t]) begin
            fails++;
            $display("FAIL directed_%h: o=%h n=%0d z=%b lat=%0d required o=%h n=%0d z=%b lat=%0d",
                     vin[t], ro, rn, rz, lat, xo[t], xn[t], vin[t] == '0, xl[t]);
         end
      end
   endtask

   task automatic test_reset_mid_shift();
      @(negedge clk);
      in_valid = 1'b1; i = 8'h01;
`ifdef SHIFT_NORM_SIGNED_EN
      sgn = 1'b0;
`endif
      @(posedge clk);
      #1 in_valid = 1'b0;
      repeat (3) @(posedge clk);
      #2 nrst = 1'b0;
      #1;
      tests++;
      if (out_valid !== 1'b0 || in_ready !== 1'b1 || o !== '0 || n !== '0) begin
         fails++;
         $display("FAIL reset_mid_shift: ov=%b ir=%b o=%h n=%0d required ov=0 ir=1 o=00 n=0",
                  out_valid, in_ready, o, n);
      end
      @(negedge clk);
      nrst = 1'b1;
      for (int k = 0; k < 15; k++) begin
         @(negedge clk);
         tests++;
         if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            fails++;
            $display("FAIL reset_no_result: cycle %0d ov=%b ir=%b required ov=0 ir=1",
                     k, out_valid, in_ready);
         end
      end
   endtask

   task automatic test_backpressure();
      logic [W-1:0] ro; logic [CW-1:0] rn; logic rz; int lat;
      do_op(8'h20, 1'b0, 5, 1'b1, ro, rn, rz, lat);
      tests++;
      if (ro !== 8'h80 || rn !== CW'(2) || rz !== 1'b0 || lat != 4) begin
         fails++;
         $display("FAIL backpressure: o=%h n=%0d z=%b lat=%0d required o=80 n=2 z=0 lat=4",
                  ro, rn, rz, lat);
      end
      for (int k = 0; k < 12; k++) begin
         @(negedge clk);
         tests++;
         if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            fails++;
            $display("FAIL poke_ignored: cycle %0d ov=%b ir=%b required ov=0 ir=1",
                     k, out_valid, in_ready);
         end
      end
   endtask

   task automatic test_back_to_back();
      logic [W-1:0]  qo [$];
      logic [CW-1:0] qn [$];
      int accepts = 0;
      out_ready = 1'b1;
      for (int c = 0; c < 40; c++) begin
         @(negedge clk);
         if (out_valid) begin qo.push_back(o); qn.push_back(n); end
         in_valid = (accepts < 2);
         i = (accepts == 0) ? 8'h40 : 8'h08;
`ifdef SHIFT_NORM_SIGNED_EN
         sgn = 1'b0;
`endif
         @(posedge clk);
         if (in_valid && in_ready) accepts++;
      end
      @(negedge clk);
      in_valid = 1'b0; out_ready = 1'b0;
      tests++;
      if (qo.size() != 2) begin
         fails++;
         $display("FAIL b2b_count: results=%0d required=2", qo.size());
      end else begin
         tests++;
         if (qo[0] !== 8'h80 || qn[0] !== CW'(1) || qo[1] !== 8'h80 || qn[1] !== CW'(4)) begin
            fails++;
            $display("FAIL b2b_order: (%h,%0d) (%h,%0d) required (80,1) (80,4)",
                     qo[0], qn[0], qo[1], qn[1]);
         end
      end
   endtask

   task automatic test_random();
      logic [W-1:0] x, ro, eo; logic [CW-1:0] rn, en; logic rz, ez, s; int lat, el;
      for (int t = 0; t < 60; t++) begin
         case ($urandom_range(0, 3))
            0:       x = W'(1) << $urandom_range(0, W - 1);
            1:       x = W'($urandom) >> $urandom_range(0, W - 1);
            default: x = W'($urandom);
         endcase
`ifdef SHIFT_NORM_SIGNED_EN
         s = 1'($urandom);
`else
         s = 1'b0;
`endif
         ref_norm(x, s, eo, en, ez, el);
         do_op(x, s, int'($urandom_range(0, 3)), 1'b0, ro, rn, rz, lat);
         tests++;
         if (ro !== eo || rn !== en || rz !== ez || lat != el) begin
            fails++;
            $display("FAIL random: in=%h sgn=%b o=%h n=%0d z=%b lat=%0d required o=%h n=%0d z=%b lat=%0d",
                     x, s, ro, rn, rz, lat, eo, en, ez, el);
         end
      end
   endtask

`ifdef SHIFT_NORM_SIGNED_EN
   task automatic test_signed();
      logic [W-1:0] vin [3] = '{8'hF3, 8'hFF, 8'h00};
      logic [W-1:0] xo [3]  = '{8'h98, 8'h80, 8'h00};
      int           xn [3]  = '{3, 7, 7};
      logic         xz [3]  = '{1'b0, 1'b0, 1'b1};
      logic [W-1:0] ro; logic [CW-1:0] rn; logic rz; int lat;
      for (int t = 0; t < 3; t++) begin
         do_op(vin[t], 1'b1, 1, 1'b0, ro, rn, rz, lat);
         tests++;
         if (ro !== xo[t] || rn !== CW'(xn[t]) || rz !== xz[t]) begin
            fails++;
            $display("FAIL signed_%h: o=%h n=%0d z=%b required o=%h n=%0d z=%b",
                     vin[t], ro, rn, rz, xo[t], xn[t], xz[t]);
         end
      end
   endtask
`endif

   initial begin
      test_reset();
      test_directed();
      test_reset_mid_shift();
      test_backpressure();
      test_back_to_back();
`ifdef SHIFT_NORM_SIGNED_EN
      test_signed();
`endif
      test_random();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/shift_normalizer.md
# shift_normalizer

Sequential normalizer: accepts a data word, left-shifts it one bit per cycle until its MSB is set, and returns the normalized word with the shift amount applied. It recovers the shift count `n` from data, the inverse of the combinational shift/rotate unit. Feeding `o` back through that unit as a logical right shift by `n` reproduces the original input. It sits in front of the shift/rotate datapath with valid/ready handshakes on both sides.

## Interface
- `WIDTH`, 8: data width; must be a power of two, minimum 4.
- `CW`, localparam `$clog2(WIDTH)+1`: count width. It holds 0..WIDTH, which is 4 bits at the default.
- `clk` input 1: single clock; all state changes on the rising edge.
- `nrst` input 1: reset; asynchronous, active-low.
- `in_valid` input 1: `i` (and `sgn` when compiled in) is valid this cycle.
- `in_ready` output 1: block can accept; high only in IDLE.
- `i` input WIDTH: word to normalize.
- `sgn` input 1: signed normalization request. Present only with `SHIFT_NORM_SIGNED_EN`.
- `out_valid` output 1: `o`, `n`, `zero` valid; high only in DONE.
- `out_ready` input 1: consumer takes the result.
- `o` output WIDTH: normalized word.
- `n` output CW: number of left shifts applied.
- `zero` output 1: input was all zeros.

## Operation
- States: IDLE, SHIFT, DONE. The encoding is free.
- **IDLE**
  - `in_ready`=1.
  - On `in_valid`: latch `i` into `data`, clear `cnt` to 0, latch `sgn`, go to SHIFT.
  - Without `in_valid`: stay.
- **SHIFT** (checks use the registered `data`):
  - If `data`==0: set `cnt`=WIDTH, `zero`=1, go to DONE.
  - Else, if the stop condition holds: go to DONE. The stop condition is `data[WIDTH-1]`==1 (unsigned).
  - Else: `data <= data << 1` (zero fill), `cnt <= cnt+1`, stay in SHIFT.
- **DONE**
  - `out_valid`=1.
  - `o`=`data`, `n`=`cnt`, `zero` as set.
  - Outputs are held stable until `out_ready`=1, then go to IDLE.
- Arithmetic:
  - For nonzero input, `n` equals the leading-zero count, range 0..WIDTH-1.
  - `cnt` never exceeds WIDTH, because the zero check precedes shifting.
- `in_valid` is ignored outside IDLE; no input is dropped silently because `in_ready`=0 then.
- `out_ready` is ignored outside DONE.
- Result registers hold their last value in IDLE and SHIFT; only `out_valid` qualifies them.

## Timing
- Reset (`nrst`=0, asynchronous):
  - State goes to IDLE.
  - `in_ready`=1, `out_valid`=0, `o`=0, `n`=0, `zero`=0.
  - Reset mid-SHIFT or in DONE abandons the operation; no output is produced.
- Accept happens at edge T.
- For nonzero input with k leading zeros (unsigned), `out_valid` rises after edge T+k+1. Latency is k+2 cycles from the accept cycle to the first `out_valid` cycle.
  - Minimum latency is 2 cycles (MSB already set).
  - Maximum latency is WIDTH+1 cycles.
- Zero input: `out_valid` rises after edge T+1.
- DONE with `out_ready`=1 lasts one cycle. `in_ready` returns the next cycle, so there is no same-cycle output/input overlap.
- Throughput is one operation per (latency + 1) cycles at best.

## Configuration
- `SHIFT_NORM_SIGNED_EN`
  - Defined:
    - The `sgn` port exists.
    - With `sgn`=1, the stop condition is `data[WIDTH-1] != data[WIDTH-2]`, and the zero check becomes "`data` is all-zeros or all-ones". That case gives `n`=WIDTH-1, `o` = the input shifted by WIDTH-1, and `zero`=1 only for all-zeros.
    - With `sgn`=0, behaviour is exactly as in Operation.
  - Undefined: no `sgn` port; unsigned behaviour only.

## Test plan
- Reset: assert `nrst`=0 mid-SHIFT (input 8'h01 accepted) -> `out_valid`=0, `in_ready`=1, `o`=0, `n`=0 immediately; no result after release.
- Unsigned: `i`=8'h80 -> `o`=8'h80, `n`=0, latency 2. `i`=8'h01 -> `o`=8'h80, `n`=7, latency 9. `i`=8'h13 -> `o`=8'h98, `n`=3.
- Zero: `i`=8'h00 -> `o`=8'h00, `n`=8, `zero`=1, `out_valid` one cycle after SHIFT entry.
- Backpressure: `i`=8'h20 with `out_ready` low for 5 cycles -> `o`=8'h80, `n`=2 stable throughout; `in_ready`=0, and an `in_valid` pulse of 8'hFF is not accepted.
- Back-to-back: `in_valid` held with 8'h40 then 8'h08 -> results (8'h80,1) then (8'h80,4), each exactly once, in order.
- Signed (with `SHIFT_NORM_SIGNED_EN`):
  - `sgn`=1, `i`=8'hF3 -> `o`=8'h98, `n`=3.
  - `sgn`=1, `i`=8'hFF -> `o`=8'h80, `n`=7, `zero`=0.
  - `sgn`=1, `i`=8'h00 -> `o`=8'h00, `n`=7, `zero`=1.
